// File: rtl/msx_config_parser.sv
// MSX configuration stream parser: validates the "MSX" magic, then decodes
// fixed 4-byte records into block-table and slot-expander write strobes.
module msx_config_parser #(
    parameter logic [7:0] MAGIC0 = 8'h4D,
    parameter logic [7:0] MAGIC1 = 8'h53,
    parameter logic [7:0] MAGIC2 = 8'h58
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stream_end,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       blk_we,
    output logic [5:0] blk_addr,
    output logic [3:0] blk_ref_ram,
    output logic [1:0] blk_offset_ram,
    output logic [4:0] blk_mapper,
    output logic [3:0] blk_device,
    output logic       exp_we,
    output logic [1:0] exp_slot,
    output logic       exp_en,
    output logic       exp_wo,
    output logic [7:0] exp_init,
    output logic       busy,
    output logic       done,
    output logic [2:0] error
);

    localparam int unsigned CNT_W = 2;
    localparam int unsigned ERR_W = 3;

    localparam logic [2:0] CONF_BLOCK   = 3'd0;
    localparam logic [2:0] CONF_LAYOUT  = 3'd2;
    localparam logic [2:0] CONF_UNUSED5 = 3'd5;
    localparam logic [2:0] CONF_UNUSED6 = 3'd6;
    localparam logic [2:0] CONF_END     = 3'd7;

    localparam logic [ERR_W-1:0] ERR_NONE                = 3'd0;
    localparam logic [ERR_W-1:0] ERR_BAD_MSX_CONF        = 3'd1;
    localparam logic [ERR_W-1:0] ERR_NOT_SUPPORTED_CONF  = 3'd2;
    localparam logic [ERR_W-1:0] ERR_NOT_SUPPORTED_BLOCK = 3'd3;
    localparam logic [ERR_W-1:0] ERR_DEVICE_MISSING      = 3'd6;

    localparam logic [4:0] MAPPER_UNUSED    = 5'd30;
    localparam logic [3:0] DEV_RESET_STATUS = 4'd13;

    typedef enum logic [2:0] {
        S_IDLE, S_MAGIC, S_REC, S_EXEC, S_DONE, S_FAIL
    } state_t;

    typedef enum logic [1:0] {
        ACT_NOP, ACT_END, ACT_ERR
    } act_t;

    state_t           state_q, state_d;
    act_t             act_q, act_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       rec0_q, rec0_d;
    logic [7:0]       rec1_q, rec1_d;
    logic [7:0]       rec2_q, rec2_d;
    logic [ERR_W-1:0] act_err_q, act_err_d;
    logic             se_pend_q, se_pend_d;
    logic [ERR_W-1:0] error_q, error_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             blk_we_q, blk_we_d;
    logic [5:0]       blk_addr_q, blk_addr_d;
    logic [3:0]       blk_ref_ram_q, blk_ref_ram_d;
    logic [1:0]       blk_offset_ram_q, blk_offset_ram_d;
    logic [4:0]       blk_mapper_q, blk_mapper_d;
    logic [3:0]       blk_device_q, blk_device_d;
    logic             exp_we_q, exp_we_d;
    logic [1:0]       exp_slot_q, exp_slot_d;
    logic             exp_en_q, exp_en_d;
    logic             exp_wo_q, exp_wo_d;
    logic [7:0]       exp_init_q, exp_init_d;

    logic       accept;
    logic [7:0] magic_exp;
    logic [2:0] rec_conf;

    assign rec_conf = rec0_q[6:4];

    // Next-state, record decode and registered-output computation
    always_comb begin
        state_d          = state_q;
        act_d            = act_q;
        cnt_d            = cnt_q;
        rec0_d           = rec0_q;
        rec1_d           = rec1_q;
        rec2_d           = rec2_q;
        act_err_d        = act_err_q;
        se_pend_d        = 1'b0;
        error_d          = error_q;
        blk_we_d         = 1'b0;
        blk_addr_d       = blk_addr_q;
        blk_ref_ram_d    = blk_ref_ram_q;
        blk_offset_ram_d = blk_offset_ram_q;
        blk_mapper_d     = blk_mapper_q;
        blk_device_d     = blk_device_q;
        exp_we_d         = 1'b0;
        exp_slot_d       = exp_slot_q;
        exp_en_d         = exp_en_q;
        exp_wo_d         = exp_wo_q;
        exp_init_d       = exp_init_q;
        accept           = in_valid && in_ready_q && !start;

        case (cnt_q)
            2'd0:    magic_exp = MAGIC0;
            2'd1:    magic_exp = MAGIC1;
            default: magic_exp = MAGIC2;
        endcase

        if (start) begin
            state_d = S_MAGIC;
            cnt_d   = '0;
            error_d = ERR_NONE;
        end else begin
            case (state_q)
                S_MAGIC: begin
                    if (accept) begin
                        if (in_data != magic_exp) begin
                            state_d = S_FAIL;
                            error_d = ERR_BAD_MSX_CONF;
                        end else if (cnt_q == CNT_W'(2)) begin
                            state_d = S_REC;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    if (stream_end) begin
                        state_d = S_FAIL;
                        error_d = ERR_BAD_MSX_CONF;
                    end
                end
                S_REC: begin
                    if (accept) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        case (cnt_q)
                            2'd0:    rec0_d = in_data[7:1];
                            2'd1:    rec1_d = in_data;
                            2'd2:    rec2_d = in_data;
                            default: ;
                        endcase
                    end
                    if (accept && cnt_q == CNT_W'(3)) begin
                        // Record complete: decide strobes now so they appear in EXEC
                        state_d   = S_EXEC;
                        se_pend_d = stream_end;
                        act_d     = ACT_NOP;
                        act_err_d = ERR_NONE;
                        case (rec_conf)
                            CONF_BLOCK: begin
                                if (rec2_q[4:0] >= MAPPER_UNUSED) begin
                                    act_d     = ACT_ERR;
                                    act_err_d = ERR_NOT_SUPPORTED_BLOCK;
                                end else if (in_data[3:0] > DEV_RESET_STATUS) begin
                                    act_d     = ACT_ERR;
                                    act_err_d = ERR_DEVICE_MISSING;
                                end else begin
                                    blk_we_d         = 1'b1;
                                    blk_addr_d       = {rec0_q[3:0], rec1_q[7:6]};
                                    blk_ref_ram_d    = rec1_q[5:2];
                                    blk_offset_ram_d = rec1_q[1:0];
                                    blk_mapper_d     = rec2_q[4:0];
                                    blk_device_d     = in_data[3:0];
                                end
                            end
                            CONF_LAYOUT: begin
                                exp_we_d   = 1'b1;
                                exp_slot_d = rec0_q[3:2];
                                exp_en_d   = rec1_q[0];
                                exp_wo_d   = rec1_q[1];
                                exp_init_d = rec2_q;
                            end
                            CONF_UNUSED5, CONF_UNUSED6: begin
                                act_d     = ACT_ERR;
                                act_err_d = ERR_NOT_SUPPORTED_CONF;
                            end
                            CONF_END: act_d = ACT_END;
                            default:  act_d = ACT_NOP;
                        endcase
                    end else if (stream_end) begin
                        state_d = S_FAIL;
                        error_d = ERR_BAD_MSX_CONF;
                    end
                end
                S_EXEC: begin
                    if (se_pend_q || stream_end) begin
                        state_d = S_FAIL;
                        error_d = ERR_BAD_MSX_CONF;
                    end else begin
                        case (act_q)
                            ACT_ERR: begin
                                state_d = S_FAIL;
                                error_d = act_err_q;
                            end
                            ACT_END: state_d = S_DONE;
                            default: state_d = S_REC;
                        endcase
                    end
                end
                default: ;
            endcase
        end

        in_ready_d = (state_d == S_MAGIC) || (state_d == S_REC) ||
                     (state_d == S_DONE)  || (state_d == S_FAIL);
        busy_d     = (state_d == S_MAGIC) || (state_d == S_REC) ||
                     (state_d == S_EXEC);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            act_q            <= ACT_NOP;
            cnt_q            <= '0;
            rec0_q           <= '0;
            rec1_q           <= '0;
            rec2_q           <= '0;
            act_err_q        <= ERR_NONE;
            se_pend_q        <= 1'b0;
            error_q          <= ERR_NONE;
            in_ready_q       <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            blk_we_q         <= 1'b0;
            blk_addr_q       <= '0;
            blk_ref_ram_q    <= '0;
            blk_offset_ram_q <= '0;
            blk_mapper_q     <= '0;
            blk_device_q     <= '0;
            exp_we_q         <= 1'b0;
            exp_slot_q       <= '0;
            exp_en_q         <= 1'b0;
            exp_wo_q         <= 1'b0;
            exp_init_q       <= '0;
        end else begin
            state_q          <= state_d;
            act_q            <= act_d;
            cnt_q            <= cnt_d;
            rec0_q           <= rec0_d;
            rec1_q           <= rec1_d;
            rec2_q           <= rec2_d;
            act_err_q        <= act_err_d;
            se_pend_q        <= se_pend_d;
            error_q          <= error_d;
            in_ready_q       <= in_ready_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            blk_we_q         <= blk_we_d;
            blk_addr_q       <= blk_addr_d;
            blk_ref_ram_q    <= blk_ref_ram_d;
            blk_offset_ram_q <= blk_offset_ram_d;
            blk_mapper_q     <= blk_mapper_d;
            blk_device_q     <= blk_device_d;
            exp_we_q         <= exp_we_d;
            exp_slot_q       <= exp_slot_d;
            exp_en_q         <= exp_en_d;
            exp_wo_q         <= exp_wo_d;
            exp_init_q       <= exp_init_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign blk_we         = blk_we_q;
    assign blk_addr       = blk_addr_q;
    assign blk_ref_ram    = blk_ref_ram_q;
    assign blk_offset_ram = blk_offset_ram_q;
    assign blk_mapper     = blk_mapper_q;
    assign blk_device     = blk_device_q;
    assign exp_we         = exp_we_q;
    assign exp_slot       = exp_slot_q;
    assign exp_en         = exp_en_q;
    assign exp_wo         = exp_wo_q;
    assign exp_init       = exp_init_q;

endmodule

// File: tb/tb_msx_config_parser.sv
// Directed bench for msx_config_parser: inputs driven on the falling edge,
// outputs sampled on the falling edge, strobes counted by a rising-edge monitor.
module tb_msx_config_parser;

    logic       clk = 1'b0;
    logic       reset_n, start, stream_end, in_valid;
    logic [7:0] in_data;
    logic       in_ready, blk_we, exp_we, exp_en, exp_wo, busy, done;
    logic [5:0] blk_addr;
    logic [3:0] blk_ref_ram, blk_device;
    logic [1:0] blk_offset_ram, exp_slot;
    logic [4:0] blk_mapper;
    logic [7:0] exp_init;
    logic [2:0] error;

    int checks = 0;
    int failures = 0;
    int blk_cnt = 0;
    int exp_cnt = 0;
    int overlap_cnt = 0;
    int outside_cnt = 0;
    int stalls;

    always #5 clk = ~clk;

    msx_config_parser dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stream_end(stream_end),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .blk_we(blk_we), .blk_addr(blk_addr), .blk_ref_ram(blk_ref_ram),
        .blk_offset_ram(blk_offset_ram), .blk_mapper(blk_mapper),
        .blk_device(blk_device), .exp_we(exp_we), .exp_slot(exp_slot),
        .exp_en(exp_en), .exp_wo(exp_wo), .exp_init(exp_init),
        .busy(busy), .done(done), .error(error)
    );

    // Strobe monitor: counts pulses and flags illegal overlap or strobes outside a busy cycle
    always @(posedge clk) begin
        if (blk_we) blk_cnt <= blk_cnt + 1;
        if (exp_we) exp_cnt <= exp_cnt + 1;
        if (blk_we && exp_we) overlap_cnt <= overlap_cnt + 1;
        if ((blk_we || exp_we) && !busy) outside_cnt <= outside_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a byte, wait (bounded) for in_ready, return after the accepting edge
    task automatic send_byte(input logic [7:0] b, output int n);
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
        tick();
    endtask

    task automatic do_start();
        in_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_magic();
        int s;
        send_byte(8'h4D, s);
        send_byte(8'h53, s);
        send_byte(8'h58, s);
    endtask

    task automatic send_rec(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        int s;
        send_byte(b0, s);
        send_byte(b1, s);
        send_byte(b2, s);
        send_byte(b3, s);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stream_end = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick(); tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_blk_we", 32'(blk_we), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("idle_in_ready", 32'(in_ready), 32'd0);

        // Valid block record, then END
        do_start();
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_in_ready", 32'(in_ready), 32'd1);
        send_magic();
        send_rec(8'h00, 8'h5B, 8'h07, 8'h0D);
        chk("blk_exec_we", 32'(blk_we), 32'd1);
        chk("blk_exec_ready", 32'(in_ready), 32'd0);
        chk("blk_addr", 32'(blk_addr), 32'h01);
        chk("blk_ref_ram", 32'(blk_ref_ram), 32'd6);
        chk("blk_offset_ram", 32'(blk_offset_ram), 32'd3);
        chk("blk_mapper", 32'(blk_mapper), 32'd7);
        chk("blk_device", 32'(blk_device), 32'd13);
        in_valid = 1'b0;
        tick();
        chk("blk_after_we", 32'(blk_we), 32'd0);
        chk("blk_after_ready", 32'(in_ready), 32'd1);
        send_rec(8'hE0, 8'h00, 8'h00, 8'h00);
        in_valid = 1'b0;
        tick();
        chk("end_done", 32'(done), 32'd1);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_error", 32'(error), 32'd0);
        chk("end_blk_cnt", 32'(blk_cnt), 32'd1);
        chk("end_exp_cnt", 32'(exp_cnt), 32'd0);

        // Bad magic
        do_start();
        chk("start_clr_done", 32'(done), 32'd0);
        send_byte(8'h4D, stalls);
        send_byte(8'h53, stalls);
        send_byte(8'h59, stalls);
        in_valid = 1'b0;
        chk("badmagic_error", 32'(error), 32'd1);
        chk("badmagic_busy", 32'(busy), 32'd0);
        chk("badmagic_drain", 32'(in_ready), 32'd1);
        chk("badmagic_blk_cnt", 32'(blk_cnt), 32'd1);

        // Layout record then END
        do_start();
        chk("start_clr_error", 32'(error), 32'd0);
        send_magic();
        send_rec(8'h48, 8'h03, 8'hA5, 8'h00);
        chk("lay_exp_we", 32'(exp_we), 32'd1);
        chk("lay_blk_we", 32'(blk_we), 32'd0);
        chk("lay_slot", 32'(exp_slot), 32'd1);
        chk("lay_en", 32'(exp_en), 32'd1);
        chk("lay_wo", 32'(exp_wo), 32'd1);
        chk("lay_init", 32'(exp_init), 32'hA5);
        send_rec(8'hE0, 8'h00, 8'h00, 8'h00);
        in_valid = 1'b0;
        tick();
        chk("lay_done", 32'(done), 32'd1);
        chk("lay_error", 32'(error), 32'd0);
        chk("lay_exp_cnt", 32'(exp_cnt), 32'd1);

        // Unsupported mapper, then missing device
        do_start();
        send_magic();
        send_rec(8'h00, 8'h00, 8'h1E, 8'h00);
        in_valid = 1'b0;
        chk("map_no_we", 32'(blk_we), 32'd0);
        tick();
        chk("map_error", 32'(error), 32'd3);
        do_start();
        send_magic();
        send_rec(8'h00, 8'h00, 8'h01, 8'h0E);
        in_valid = 1'b0;
        chk("dev_no_we", 32'(blk_we), 32'd0);
        tick();
        chk("dev_error", 32'(error), 32'd6);
        chk("err_blk_cnt", 32'(blk_cnt), 32'd1);

        // Reserved record type
        do_start();
        send_magic();
        send_rec(8'hA0, 8'h00, 8'h00, 8'h00);
        in_valid = 1'b0;
        tick();
        chk("conf5_error", 32'(error), 32'd2);

        // Truncated stream, then reset mid-record
        do_start();
        send_magic();
        send_byte(8'h00, stalls);
        send_byte(8'h5B, stalls);
        in_valid = 1'b0;
        stream_end = 1'b1;
        tick();
        stream_end = 1'b0;
        chk("trunc_error", 32'(error), 32'd1);
        chk("trunc_busy", 32'(busy), 32'd0);
        do_start();
        send_magic();
        send_byte(8'h00, stalls);
        send_byte(8'h5B, stalls);
        in_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_addr", 32'(blk_addr), 32'd0);
        chk("midrst_init", 32'(exp_init), 32'd0);
        chk("midrst_mapper", 32'(blk_mapper), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("midrst_idle", 32'(in_ready), 32'd0);

        // stream_end coincident with the completing byte: strobe, then FAIL
        do_start();
        send_magic();
        send_byte(8'h00, stalls);
        send_byte(8'h5B, stalls);
        send_byte(8'h07, stalls);
        in_data = 8'h0D;
        stream_end = 1'b1;
        tick();
        stream_end = 1'b0;
        in_valid = 1'b0;
        chk("coend_we", 32'(blk_we), 32'd1);
        tick();
        chk("coend_error", 32'(error), 32'd1);
        chk("coend_done", 32'(done), 32'd0);
        chk("coend_blk_cnt", 32'(blk_cnt), 32'd2);

        // Back-to-back records with in_valid held high
        do_start();
        send_magic();
        send_rec(8'h00, 8'h5B, 8'h07, 8'h0D);
        chk("b2b_exec_ready", 32'(in_ready), 32'd0);
        send_byte(8'h08, stalls);
        chk("b2b_stall", 32'(stalls), 32'd1);
        send_byte(8'hC4, stalls);
        chk("b2b_nostall", 32'(stalls), 32'd0);
        send_byte(8'h05, stalls);
        send_byte(8'h01, stalls);
        in_valid = 1'b0;
        chk("b2b_we", 32'(blk_we), 32'd1);
        chk("b2b_addr", 32'(blk_addr), 32'h13);
        chk("b2b_ref_ram", 32'(blk_ref_ram), 32'd1);
        chk("b2b_offset", 32'(blk_offset_ram), 32'd0);
        chk("b2b_mapper", 32'(blk_mapper), 32'd5);
        chk("b2b_device", 32'(blk_device), 32'd1);
        tick();
        chk("b2b_blk_cnt", 32'(blk_cnt), 32'd4);
        chk("strobe_overlap", 32'(overlap_cnt), 32'd0);
        chk("strobe_outside", 32'(outside_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/msx_config_parser.md
MSX_CONFIG_PARSER -- requirements
Module: msx_config_parser

Interface
REQ-001 SHALL have parameter MAGIC0, default 8'h4D, first magic byte ('M').
REQ-002 SHALL have parameter MAGIC1, default 8'h53, second magic byte ('S').
REQ-003 SHALL have parameter MAGIC2, default 8'h58, third magic byte ('X').
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins a new configuration stream.
REQ-007 SHALL have port stream_end  input  1  one-cycle pulse: source has no more bytes.
REQ-008 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-009 SHALL have port in_data  input  8  configuration stream byte.
REQ-010 SHALL have port in_ready  output  1  parser accepts a byte this cycle.
REQ-011 SHALL have port blk_we  output  1  one-cycle block-table write strobe.
REQ-012 SHALL have port blk_addr  output  6  {slot[1:0], subslot[1:0], page[1:0]}.
REQ-013 SHALL have port blk_ref_ram  output  4  MSX::block_t ref_ram.
REQ-014 SHALL have port blk_offset_ram  output  2  MSX::block_t offset_ram.
REQ-015 SHALL have port blk_mapper  output  5  mapper_typ_t code.
REQ-016 SHALL have port blk_device  output  4  device_t code.
REQ-017 SHALL have port exp_we  output  1  one-cycle slot-expander write strobe.
REQ-018 SHALL have port exp_slot  output  2  expander slot index.
REQ-019 SHALL have port exp_en, exp_wo  output  1 each  MSX::slot_expander_t en/wo.
REQ-020 SHALL have port exp_init  output  8  MSX::slot_expander_t init.
REQ-021 SHALL have port busy  output  1  high in MAGIC, REC, EXEC.
REQ-022 SHALL have port done  output  1  level, high in DONE.
REQ-023 SHALL have port error  output  3  error_t code, held until next start or reset.

Function
REQ-024 SHALL implement states IDLE, MAGIC, REC, EXEC, DONE, FAIL.
REQ-025 SHALL accept a byte only when in_valid and in_ready are both high.
REQ-026 SHALL drive in_ready high in MAGIC and REC, low in IDLE and EXEC, high in DONE and FAIL (bytes drained and discarded).
REQ-027 On start, from any state: go to MAGIC, clear error to ERR_NONE, clear byte counter; a byte presented in the same cycle is not accepted.
REQ-028 MAGIC: three accepted bytes compared with MAGIC0..2 in order; any mismatch -> FAIL with ERR_BAD_MSX_CONF; third match -> REC.
REQ-029 REC: collect fixed 4-byte records via a 2-bit counter; 4th byte -> EXEC with counter wrapped to 0.
REQ-030 Byte0 decode: [7:5] conf_t, [4:3] slot, [2:1] subslot, [0] ignored.
REQ-031 CONF_BLOCK: byte1 [7:6] page, [5:2] ref_ram, [1:0] offset_ram; byte2 [4:0] mapper; byte3 [3:0] device.
REQ-032 CONF_BLOCK with mapper = MAPPER_UNUSED (30) or 31 -> FAIL, ERR_NOT_SUPPORTED_BLOCK, no blk_we.
REQ-033 CONF_BLOCK with device > DEV_RESET_STATUS (13) -> FAIL, ERR_DEVICE_MISSING, no blk_we.
REQ-034 Valid CONF_BLOCK: blk_we high exactly one cycle in EXEC, all blk_* fields valid that cycle, then REC.
REQ-035 CONF_LAYOUT: byte1 bit0 en, bit1 wo; byte2 init; byte3 ignored; exp_we one cycle in EXEC with exp_slot = slot, then REC.
REQ-036 CONF_DEVICE, CONF_CARTRIGE, CONF_BLOCK_FW: no strobe; EXEC -> REC.
REQ-037 CONF_UNUSED5/6 -> FAIL, ERR_NOT_SUPPORTED_CONF.
REQ-038 CONF_END: EXEC -> DONE, error stays ERR_NONE.
REQ-039 stream_end while in MAGIC, REC or EXEC -> FAIL, ERR_BAD_MSX_CONF, partial record discarded; ignored in IDLE, DONE, FAIL.
REQ-040 stream_end and an accepted byte in the same cycle: byte processed first; if it completes a record, EXEC occurs next cycle and stream_end is then treated as arrived in EXEC.
REQ-041 Latency: 4th record byte accepted in cycle N -> strobe in cycle N+1 -> in_ready high in cycle N+2.
REQ-042 blk_we and exp_we SHALL never be high in the same cycle or outside EXEC.

Reset
REQ-043 reset_n low at a clock edge: state IDLE, counter 0, error ERR_NONE, all strobes, busy, done, in_ready 0, all data outputs 0; overrides start and mid-record state.

Verification
REQ-044 start, bytes 4D 53 58, 00 5B 1E 0D... adjusted: 00 5B 07 0D -> blk_we once, blk_addr 0x01, ref_ram 6, offset_ram 3, mapper 7, device 13.
REQ-045 start, 4D 53 59 -> FAIL, error 1 (ERR_BAD_MSX_CONF), no strobes.
REQ-046 start, magic, 48 03 A5 00 (LAYOUT slot 1) then E0 00 00 00 -> exp_we once, exp_slot 1, en 1, wo 1, init A5; done 1, error 0.
REQ-047 start, magic, 00 00 1E 00 -> error 3 (ERR_NOT_SUPPORTED_BLOCK); second block record 00 00 01 0E -> error 6 (ERR_DEVICE_MISSING).
REQ-048 start, magic, two record bytes, stream_end -> FAIL error 1; then reset_n low mid-record -> all outputs 0, state IDLE.
REQ-049 in_valid held high throughout a record -> in_ready low exactly one cycle (EXEC) after each 4th byte; no byte lost or duplicated.
